// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load returns and ALU results into one regfile write port.
// Optional load size/sign extension is compiled in with `define WB_LOAD_EXT_EN.
module wb_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          mem_valid,
  input  logic [4:0]                    mem_rd,
  input  logic [XLEN-1:0]               mem_data,
  input  logic [1:0]                    mem_size,
  input  logic                          mem_unsigned,
  output logic                          write_enable,
  output logic [4:0]                    waddr,
  output logic [XLEN-1:0]               wdata,
  output logic [$clog2(FIFO_DEPTH):0]   alu_pending
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  wb_entry_t        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             sel_valid;
  wb_entry_t        sel_entry;
  logic [XLEN-1:0]  load_data;

  // Ready only reflects stored occupancy; a full FIFO never passes a result through.
  assign alu_ready   = rst_n && (count_q < CNT_W'(FIFO_DEPTH));
  assign alu_pending = count_q;

`ifdef WB_LOAD_EXT_EN
  logic ext_bit;

  // Extension bit is the top bit of the loaded size, forced to 0 for unsigned loads.
  always_comb begin
    ext_bit   = 1'b0;
    load_data = mem_data;
    case (mem_size)
      2'd0: begin
        ext_bit   = ~mem_unsigned & mem_data[7];
        load_data = {{(XLEN-8){ext_bit}}, mem_data[7:0]};
      end
      2'd1: begin
        ext_bit   = ~mem_unsigned & mem_data[15];
        load_data = {{(XLEN-16){ext_bit}}, mem_data[15:0]};
      end
      2'd2: begin
        ext_bit   = ~mem_unsigned & mem_data[31];
        load_data = {{(XLEN-32){ext_bit}}, mem_data[31:0]};
      end
      default: load_data = mem_data;
    endcase
  end
`else
  logic unused_ext;

  assign load_data  = mem_data;
  assign unused_ext = ^{mem_size, mem_unsigned};
`endif

  // Priority: load, then FIFO head, then the incoming ALU result directly.
  always_comb begin
    accept     = alu_valid && alu_ready;
    fifo_empty = (count_q == '0);
    pop        = !mem_valid && !fifo_empty;
    bypass     = !mem_valid && fifo_empty && accept;
    push       = accept && !bypass;
    sel_valid  = mem_valid || !fifo_empty || accept;
    sel_entry  = {alu_rd, alu_data};
    if (mem_valid) begin
      sel_entry = {mem_rd, load_data};
    end else if (!fifo_empty) begin
      sel_entry = fifo_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {alu_rd, alu_data};
    end
  end

  // rd = 0 is consumed without a write; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
    end else begin
      write_enable <= sel_valid && (sel_entry.rd != 5'd0);
      if (sel_valid) begin
        waddr <= sel_entry.rd;
        wdata <= sel_entry.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed stimulus, expected writes queued to a scoreboard
// that a negedge monitor drains; latency and occupancy checked inline.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 64;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic            alu_ready;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            mem_valid = 1'b0;
  logic [4:0]      mem_rd = '0;
  logic [XLEN-1:0] mem_data = '0;
  logic [1:0]      mem_size = 2'd3;
  logic            mem_unsigned = 1'b0;
  logic            write_enable;
  logic [4:0]      waddr;
  logic [XLEN-1:0] wdata;
  logic [1:0]      alu_pending;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .alu_pending(alu_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every regfile write must match the next expected write.
  always @(negedge clk) begin
    if (write_enable) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got x%0d=0x%0h, want no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (waddr !== e.rd || wdata !== e.data) begin
          bad++;
          $display("FAIL sb_write: got x%0d=0x%0h, want x%0d=0x%0h", waddr, wdata, e.rd, e.data);
        end
      end
    end
  end

  // Load-extension vectors: data, size, unsigned, expected result.
  logic [XLEN-1:0] ext_data [7];
  logic [1:0]      ext_size [7];
  logic            ext_uns  [7];
  logic [XLEN-1:0] ext_exp  [7];

  initial begin
    ext_data[0] = 64'h80;                  ext_size[0] = 2'd0; ext_uns[0] = 1'b0;
    ext_data[1] = 64'h80;                  ext_size[1] = 2'd0; ext_uns[1] = 1'b1;
    ext_data[2] = 64'hFFFF_1234_0000_8001; ext_size[2] = 2'd1; ext_uns[2] = 1'b0;
    ext_data[3] = 64'hFFFF_1234_0000_7FFF; ext_size[3] = 2'd1; ext_uns[3] = 1'b0;
    ext_data[4] = 64'h0000_0001_8000_0000; ext_size[4] = 2'd2; ext_uns[4] = 1'b0;
    ext_data[5] = 64'h0000_0001_8000_0000; ext_size[5] = 2'd2; ext_uns[5] = 1'b1;
    ext_data[6] = 64'h8000_0000_0000_0001; ext_size[6] = 2'd3; ext_uns[6] = 1'b0;
`ifdef WB_LOAD_EXT_EN
    ext_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
    ext_exp[1] = 64'h0000_0000_0000_0080;
    ext_exp[2] = 64'hFFFF_FFFF_FFFF_8001;
    ext_exp[3] = 64'h0000_0000_0000_7FFF;
    ext_exp[4] = 64'hFFFF_FFFF_8000_0000;
    ext_exp[5] = 64'h0000_0000_8000_0000;
    ext_exp[6] = 64'h8000_0000_0000_0001;
`else
    for (int i = 0; i < 7; i++) ext_exp[i] = ext_data[i];
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_pending", 64'(alu_pending), 64'd0);
    chk("rst_ready", 64'(alu_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 64'(alu_ready), 64'd1);
    step();

    // Bypass: single ALU result, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    push_exp(5'd5, 64'h1234);
    step();
    alu_valid = 1'b0;
    chk("byp_we", 64'(write_enable), 64'd1);
    chk("byp_waddr", 64'(waddr), 64'd5);
    chk("byp_wdata", wdata, 64'h1234);
    chk("byp_pending", 64'(alu_pending), 64'd0);

    // Load beats a simultaneous ALU result
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'hB;
    push_exp(5'd4, 64'hB);
    push_exp(5'd3, 64'hA);
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("coll_waddr1", 64'(waddr), 64'd4);
    chk("coll_pending1", 64'(alu_pending), 64'd1);
    step();
    chk("coll_waddr2", 64'(waddr), 64'd3);
    chk("coll_pending2", 64'(alu_pending), 64'd0);
    step();
    chk("coll_idle_we", 64'(write_enable), 64'd0);
    chk("coll_hold_waddr", 64'(waddr), 64'd3);

    // Continuous loads starve the FIFO; ready drops once two results are held
    for (int c = 0; c < 4; c++) push_exp(5'(10 + c), 64'(64'h100 + c));
    push_exp(5'd20, 64'h200);
    push_exp(5'd21, 64'h201);
    begin
      int k = 0;
      for (int c = 0; c < 4; c++) begin
        mem_valid = 1'b1; mem_rd = 5'(10 + c); mem_data = 64'(64'h100 + c);
        alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 64'(64'h200 + k);
        chk($sformatf("starve_ready%0d", c), 64'(alu_ready), (c < 2) ? 64'd1 : 64'd0);
        if (c < 2) k++;
        step();
        chk($sformatf("starve_pending%0d", c), 64'(alu_pending), (c < 1) ? 64'd1 : 64'd2);
      end
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    step();
    chk("drain_pending1", 64'(alu_pending), 64'd1);
    step();
    chk("drain_pending0", 64'(alu_pending), 64'd0);
    step();

    // Load extension vectors
    for (int i = 0; i < 7; i++) begin
      mem_valid = 1'b1; mem_rd = 5'd8; mem_data = ext_data[i];
      mem_size = ext_size[i]; mem_unsigned = ext_uns[i];
      push_exp(5'd8, ext_exp[i]);
      step();
      chk($sformatf("ext_wdata%0d", i), wdata, ext_exp[i]);
    end
    mem_valid = 1'b0; mem_size = 2'd3; mem_unsigned = 1'b0;
    step();

    // rd = 0 is consumed silently; following rd = 7 writes
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h55;
    step();
    chk("rd0_we", 64'(write_enable), 64'd0);
    chk("rd0_pending", 64'(alu_pending), 64'd0);
    alu_rd = 5'd7; alu_data = 64'h77;
    push_exp(5'd7, 64'h77);
    step();
    alu_valid = 1'b0;
    chk("rd7_we", 64'(write_enable), 64'd1);
    chk("rd7_waddr", 64'(waddr), 64'd7);
    step();

    // Fill the FIFO behind loads, then reset mid-cycle: held entries must vanish
    for (int c = 0; c < 2; c++) begin
      mem_valid = 1'b1; mem_rd = 5'(1 + c); mem_data = 64'(64'h11 + c);
      alu_valid = 1'b1; alu_rd = 5'(9 + c); alu_data = 64'(64'h31 + c);
      push_exp(5'(1 + c), 64'(64'h11 + c));
      step();
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("full_pending", 64'(alu_pending), 64'd2);
    chk("full_ready", 64'(alu_ready), 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(write_enable), 64'd0);
    chk("midrst_waddr", 64'(waddr), 64'd0);
    chk("midrst_wdata", wdata, 64'd0);
    chk("midrst_pending", 64'(alu_pending), 64'd0);
    chk("midrst_ready", 64'(alu_ready), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("postrst_we%0d", c), 64'(write_enable), 64'd0);
      chk($sformatf("postrst_pending%0d", c), 64'(alu_pending), 64'd0);
    end

    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
